vector_alu: RTL and testbench
=============================

# vector_alu

Multi-cycle signed vector arithmetic unit between the register file's operand outputs (A1/A2) and its result inputs (A3/A4). On `start` it snapshots two 512-bit operand vectors and the opcode, then processes 16 lanes of 32 bits, `LANES_PER_CYCLE` lanes per clock. Each lane produces an exact 64-bit result, split into a low half (`A3_result`) and a high half (`A4_result`). A one-cycle `ready` pulse tells the register file to capture both result vectors.

## Interface

- `LANE_W`, 32: lane width in bits.
- `NUM_LANES`, 16: lanes per vector. Vector width `VW` = `NUM_LANES*LANE_W` (512).
- `LANES_PER_CYCLE`, 4: lanes computed per BUSY cycle. It must divide `NUM_LANES`. Number of groups `NG` = `NUM_LANES/LANES_PER_CYCLE`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request an operation; sampled only in IDLE or DONE.
- `opcode` input 2: 00 ADD, 01 SUB, 10 MUL, 11 AND. Sampled with `start`.
- `A1_in` input VW: operand vector A. Lane i = bits [i*LANE_W +: LANE_W].
- `A2_in` input VW: operand vector B, same lane mapping.
- `A3_result` output VW: low LANE_W bits of each lane's 2*LANE_W result.
- `A4_result` output VW: high LANE_W bits of each lane's 2*LANE_W result.
- `ready` output 1: one-cycle pulse; results are complete.
- `busy` output 1: high while in BUSY.

## Operation

- States: IDLE, BUSY, DONE.
- IDLE:
  - On `start`=1, latch `A1_in`, `A2_in` and `opcode` into internal snapshot registers.
  - Clear the group counter `grp` to 0 and go to BUSY.
  - `start`=0: stay in IDLE.
- BUSY:
  - Each cycle, compute lanes `grp*LANES_PER_CYCLE` through `grp*LANES_PER_CYCLE+LANES_PER_CYCLE-1` from the snapshot.
  - Write those lanes into the `A3_result`/`A4_result` registers, then increment `grp`.
  - After group `NG-1` is written, go to DONE.
  - `start` is ignored in BUSY.
- DONE:
  - Lasts one cycle with `ready`=1.
  - `start`=1: re-snapshot the inputs and go to BUSY (back-to-back operation).
  - `start`=0: go to IDLE.
- Results use the snapshot only. Changes to `A1_in`, `A2_in` or `opcode` after the sampling edge have no effect.
- Lane arithmetic, with a and b as signed LANE_W values and r as a 2*LANE_W result:
  - ADD: r = sign-extend(a + b), computed at LANE_W+1 bits, so the result is exact with no wrap.
  - SUB: r = sign-extend(a − b), computed at LANE_W+1 bits, exact.
  - MUL: r = a × b, full signed 2*LANE_W product, exact.
  - AND: r = {LANE_W zeros, a & b}.
- Result registers hold their value in IDLE and DONE and change only during BUSY.
  - Lanes not yet rewritten in the current operation keep the previous operation's values.
  - Outputs are defined as valid while `ready`=1 and afterwards until the next accepted `start`.
- Integration constraint: the register file captures results only when `write_enable`=0. The controller must hold `write_enable` low in the `ready` cycle.

## Timing

- Reset (`rst_n`=0, asynchronous): state IDLE, `grp`=0, snapshot registers 0, `A3_result`=0, `A4_result`=0, `ready`=0, `busy`=0.
- `start` sampled high at edge E0:
  - `busy`=1 from E0 to E(NG).
  - Group g is written at edge E(g+1).
  - `ready`=1 from E(NG) to E(NG+1). With default parameters, `ready` is high in the 5th cycle after the start edge.
- Latency: NG+1 edges from `start` sample to `ready` deasserting. Throughput with back-to-back `start` in DONE: one operation per NG+1 cycles.
- `ready` and `busy` are never high in the same cycle. `ready` is never high for two consecutive cycles.
- Reset asserted mid-BUSY: the operation is aborted, `ready` is never pulsed for it, and all outputs immediately take their reset values.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- ADD: all lanes A=0x7FFFFFFF, B=0x00000001. Required: every A3 lane 0x80000000, every A4 lane 0x00000000. `ready` pulses once, 4 edges after `start`.
- MUL: lane0 A=0xFFFFFFFF (−1) × B=0x00000002; lane15 A=0x80000000 × B=0x80000000. Required: lane0 A3=0xFFFFFFFE, A4=0xFFFFFFFF; lane15 A3=0x00000000, A4=0x40000000.
- SUB then AND back-to-back:
  - SUB with A=0, B=1 → all lanes A3=0xFFFFFFFF, A4=0xFFFFFFFF.
  - Assert `start` in the DONE cycle with AND, A=0xF0F0F0F0, B=0xFF00FF00 → A3=0xF000F000, A4=0. Busy again next cycle.
- Snapshot and ignore: change `A1_in` and `opcode`, and pulse `start`, during BUSY. Required: results match the original operands; no extra operation; exactly one `ready` pulse.
- Reset mid-op: assert `rst_n`=0 after 2 BUSY cycles. Required: outputs 0 immediately and no `ready`. A new ADD after reset completes normally with 4-cycle latency.

Source files
------------

// File: rtl/vector_alu.sv
// vector_alu: multi-cycle signed vector ALU.
// Snapshots two vectors of NUM_LANES signed lanes plus an opcode on start,
// then produces LANES_PER_CYCLE exact 2*LANE_W-bit lane results per clock.
// Low halves go to A3_result, high halves to A4_result; ready pulses once
// when the whole vector has been written.
module vector_alu #(
  parameter int LANE_W          = 32,
  parameter int NUM_LANES       = 16,
  parameter int LANES_PER_CYCLE = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  opcode,
  input  logic [NUM_LANES*LANE_W-1:0] A1_in,
  input  logic [NUM_LANES*LANE_W-1:0] A2_in,
  output logic [NUM_LANES*LANE_W-1:0] A3_result,
  output logic [NUM_LANES*LANE_W-1:0] A4_result,
  output logic                        ready,
  output logic                        busy
);

  localparam int VW    = NUM_LANES * LANE_W;
  localparam int NG    = NUM_LANES / LANES_PER_CYCLE;
  localparam int GRP_W = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NG - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01,
                            OP_MUL = 2'b10, OP_AND = 2'b11} op_e;

  state_e            state_q, state_d;
  logic [GRP_W-1:0]  grp_q;
  logic [VW-1:0]     snap_a_q, snap_b_q;
  op_e               snap_op_q;
  logic [VW-1:0]     a3_q, a4_q, a3_d, a4_d;
  logic              accept;
  int                lane;
  logic [2*LANE_W-1:0] lane_res;

  // start is only honoured while idle or in the single DONE cycle
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Exact 2*LANE_W-bit result of one lane. ADD/SUB are formed at LANE_W+1
  // bits so the carry/borrow survives, then sign-extended to full width.
  function automatic logic [2*LANE_W-1:0] lane_calc(
    input op_e               op,
    input logic [LANE_W-1:0] a,
    input logic [LANE_W-1:0] b
  );
    logic [LANE_W:0]            ext_a, ext_b, sum;
    logic signed [2*LANE_W-1:0] wide_a, wide_b;
    logic [2*LANE_W-1:0]        r;
    ext_a  = {a[LANE_W-1], a};
    ext_b  = {b[LANE_W-1], b};
    wide_a = {{LANE_W{a[LANE_W-1]}}, a};
    wide_b = {{LANE_W{b[LANE_W-1]}}, b};
    sum    = '0;
    r      = '0;
    case (op)
      OP_ADD: begin
        sum = ext_a + ext_b;
        r   = {{(LANE_W-1){sum[LANE_W]}}, sum};
      end
      OP_SUB: begin
        sum = ext_a - ext_b;
        r   = {{(LANE_W-1){sum[LANE_W]}}, sum};
      end
      // Low 2*LANE_W bits of the sign-extended product are the exact product
      OP_MUL:  r = wide_a * wide_b;
      OP_AND:  r = {{LANE_W{1'b0}}, a & b};
      default: r = '0;
    endcase
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first, so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  if (grp_q == GRP_LAST) state_d = S_DONE;
      S_DONE:  state_d = start ? S_BUSY : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs, decoded from the state register only
  always_comb begin
    busy  = (state_q == S_BUSY);
    ready = (state_q == S_DONE);
  end

  // Lane datapath: overwrite the current group's lanes while busy
  always_comb begin
    a3_d     = a3_q;
    a4_d     = a4_q;
    lane     = 0;
    lane_res = '0;
    if (state_q == S_BUSY) begin
      for (int j = 0; j < LANES_PER_CYCLE; j++) begin
        lane     = int'(grp_q) * LANES_PER_CYCLE + j;
        lane_res = lane_calc(snap_op_q,
                             snap_a_q[lane*LANE_W +: LANE_W],
                             snap_b_q[lane*LANE_W +: LANE_W]);
        a3_d[lane*LANE_W +: LANE_W] = lane_res[LANE_W-1:0];
        a4_d[lane*LANE_W +: LANE_W] = lane_res[2*LANE_W-1:LANE_W];
      end
    end
  end

  // Snapshot, group counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these wide registers are plain flops, not a RAM, and must read
      // as zero straight out of reset, so they get an async reset too.
      grp_q     <= '0;
      snap_a_q  <= '0;
      snap_b_q  <= '0;
      snap_op_q <= OP_ADD;
      a3_q      <= '0;
      a4_q      <= '0;
    end else begin
      if (accept) begin
        snap_a_q  <= A1_in;
        snap_b_q  <= A2_in;
        snap_op_q <= op_e'(opcode);
        grp_q     <= '0;
      end else if (state_q == S_BUSY) begin
        grp_q <= grp_q + GRP_W'(1);
      end
      a3_q <= a3_d;
      a4_q <= a4_d;
    end
  end

  assign A3_result = a3_q;
  assign A4_result = a4_q;

endmodule

// File: tb/tb_vector_alu.sv
// tb_vector_alu: directed bench for vector_alu with a transaction-level
// reference model and a per-cycle output compare.
module tb_vector_alu;

  localparam int LW  = 32;
  localparam int NL  = 16;
  localparam int LPC = 4;
  localparam int NG  = NL / LPC;
  localparam int VW  = NL * LW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    opcode = 2'b00;
  logic [VW-1:0] A1_in = '0;
  logic [VW-1:0] A2_in = '0;
  logic [VW-1:0] A3_result, A4_result;
  logic          ready, busy;

  int total = 0;
  int bad   = 0;
  int ready_count = 0;
  bit chk_en = 1'b0;

  vector_alu #(.LANE_W(LW), .NUM_LANES(NL), .LANES_PER_CYCLE(LPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opcode    (opcode),
    .A1_in     (A1_in),
    .A2_in     (A2_in),
    .A3_result (A3_result),
    .A4_result (A4_result),
    .ready     (ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input logic [LW-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*LW +: LW] = v;
    return r;
  endfunction

  function automatic logic [LW-1:0] lane_of(input logic [VW-1:0] v, input int i);
    return v[i*LW +: LW];
  endfunction

  // Reference arithmetic on plain 64-bit integers
  function automatic logic [2*LW-1:0] ref_lane(input logic [1:0] op,
                                               input logic [LW-1:0] a,
                                               input logic [LW-1:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    r = sa * sb;
      default: r = longint'({32'h0, a & b});
    endcase
    return r;
  endfunction

  // Reference model: edges since the last accepted start (-1 when idle).
  // Group g lands at edge g+1; ready is the cycle after the last group.
  int            since = -1;
  logic [VW-1:0] m_a = '0, m_b = '0, exp_a3 = '0, exp_a4 = '0;
  logic [1:0]    m_op = 2'b00;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        since = -1; m_a = '0; m_b = '0; m_op = 2'b00; exp_a3 = '0; exp_a4 = '0;
      end else if (since >= 0 && since < NG) begin
        for (int j = 0; j < LPC; j++) begin
          int l;
          logic [2*LW-1:0] r;
          l = since * LPC + j;
          r = ref_lane(m_op, m_a[l*LW +: LW], m_b[l*LW +: LW]);
          exp_a3[l*LW +: LW] = r[LW-1:0];
          exp_a4[l*LW +: LW] = r[2*LW-1:LW];
        end
        since++;
      end else if (start) begin
        m_a = A1_in; m_b = A2_in; m_op = opcode; since = 0;
      end else begin
        since = -1;
      end
    end
  end

  // Per-cycle compare of every output against the model
  bit prev_ready = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", busy, (since >= 0 && since < NG));
        check("ready", ready, (since == NG));
        check("A3", A3_result, exp_a3);
        check("A4", A4_result, exp_a4);
        check("ready_busy_excl", ready && busy, 0);
        check("ready_consec", ready && prev_ready, 0);
        prev_ready = ready;
        if (ready) ready_count++;
      end
    end
  end

  // Drive one start; start is sampled at the next rising edge
  task automatic go(input logic [1:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b);
    opcode = op; A1_in = a; A2_in = b; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // Wait (bounded) for ready and check how many edges it took
  task automatic wait_ready(input string name, input int exp_edges);
    int n;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ready) begin n = i; break; end
    end
    check(name, n, exp_edges);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    logic [VW-1:0] va, vb;
    int rc0;

    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_A3", A3_result, 0);
    check("rst_A4", A4_result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(1);

    // ADD without wrap
    rc0 = ready_count;
    go(2'b00, fill(32'h7FFF_FFFF), fill(32'h0000_0001));
    wait_ready("add_latency", NG);
    idle(2);
    check("add_A3", A3_result, fill(32'h8000_0000));
    check("add_A4", A4_result, fill(32'h0000_0000));
    check("add_ready_once", ready_count - rc0, 1);

    // MUL with corner lanes
    va = '0; vb = '0;
    for (int i = 1; i < NL - 1; i++) begin
      va[i*LW +: LW] = 32'(i * 1000 - 7000);
      vb[i*LW +: LW] = 32'h0001_0003;
    end
    va[0 +: LW] = 32'hFFFF_FFFF;       vb[0 +: LW] = 32'h0000_0002;
    va[15*LW +: LW] = 32'h8000_0000;   vb[15*LW +: LW] = 32'h8000_0000;
    go(2'b10, va, vb);
    wait_ready("mul_latency", NG);
    idle(1);
    check("mul_l0_A3", lane_of(A3_result, 0), 32'hFFFF_FFFE);
    check("mul_l0_A4", lane_of(A4_result, 0), 32'hFFFF_FFFF);
    check("mul_l15_A3", lane_of(A3_result, 15), 32'h0000_0000);
    check("mul_l15_A4", lane_of(A4_result, 15), 32'h4000_0000);

    // SUB then AND back-to-back from the DONE cycle
    go(2'b01, fill(32'h0), fill(32'h1));
    wait_ready("sub_latency", NG);
    check("sub_A3", A3_result, fill(32'hFFFF_FFFF));
    check("sub_A4", A4_result, fill(32'hFFFF_FFFF));
    go(2'b11, fill(32'hF0F0_F0F0), fill(32'hFF00_FF00));
    check("b2b_busy", busy, 1);
    wait_ready("and_latency", NG);
    idle(1);
    check("and_A3", A3_result, fill(32'hF000_F000));
    check("and_A4", A4_result, fill(32'h0));

    // Inputs and start changing during BUSY are ignored
    rc0 = ready_count;
    va = '0;
    for (int i = 0; i < NL; i++) va[i*LW +: LW] = 32'h10 + 32'(i);
    go(2'b00, va, fill(32'h100));
    A1_in = fill(32'hFFFF_FFFF); opcode = 2'b10; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_ready("snap_latency", NG - 1);
    idle(8);
    check("snap_l5_A3", lane_of(A3_result, 5), 32'h0000_0115);
    check("snap_A4", A4_result, fill(32'h0));
    check("snap_ready_once", ready_count - rc0, 1);
    check("snap_idle", busy, 0);

    // Reset in the middle of an operation
    rc0 = ready_count;
    go(2'b00, fill(32'h1), fill(32'h2));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_A3", A3_result, 0);
    check("midrst_A4", A4_result, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", ready, 0);
    idle(2);
    rst_n = 1'b1;
    idle(6);
    check("midrst_no_ready", ready_count - rc0, 0);
    go(2'b00, fill(32'h8000_0000), fill(32'h8000_0000));
    wait_ready("post_rst_latency", NG);
    idle(1);
    check("post_rst_A3", A3_result, fill(32'h0));
    check("post_rst_A4", A4_result, fill(32'hFFFF_FFFF));

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
